// File: rtl/ws2811_stream_encoder.sv
// WS2811/WS2812 NRZ stream encoder: valid/ready byte stream in, MSB-first timed cells plus latch low out.
// Optional WS_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_cnt output.
module ws2811_stream_encoder #(
    parameter int T_BIT   = 62,
    parameter int T0H     = 13,
    parameter int T1H     = 30,
    parameter int T_RESET = 2600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       ws_out,
    output logic       busy,
    output logic       underrun
`ifdef WS_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam int CW = $clog2(T_RESET + 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_END   = CW'(T_BIT - 1);
    localparam logic [CW-1:0] RESET_END = CW'(T_RESET - 1);
    localparam logic [CW-1:0] HIGH_0    = CW'(T0H);
    localparam logic [CW-1:0] HIGH_1    = CW'(T1H);

    if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && T_RESET > T_BIT)) begin : g_cfg_error
        $error("ws2811_stream_encoder: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIT   = 2'd1,
        GAP   = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [7:0]    sr_r, sr_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic          last_r, last_s;
    logic          accept_s, load_s, underrun_s;
    logic          ready_s, ws_s, busy_s;

    // Ready depends only on where the encoder will be, so it can be registered one cycle early.
    function automatic logic ready_for(input state_t st, input logic [CW-1:0] c,
                                       input logic [2:0] idx, input logic lst);
        logic r;
        case (st)
            IDLE:    r = 1'b1;
            GAP:     r = 1'b1;
            BIT:     r = (c == BIT_END) && (idx == 3'd0) && !lst;
            LATCH:   r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic line_for(input state_t st, input logic [CW-1:0] c,
                                      input logic msb);
        logic w;
        if (st == BIT) begin
            w = (c < (msb ? HIGH_1 : HIGH_0));
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

    assign accept_s = s_valid && s_ready;

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        sr_s       = sr_r;
        bit_idx_s  = bit_idx_r;
        last_s     = last_r;
        load_s     = 1'b0;
        underrun_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BIT: begin
                if (cnt_r != BIT_END) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else if (bit_idx_r != 3'd0) begin
                    sr_s      = {sr_r[6:0], 1'b0};
                    bit_idx_s = bit_idx_r - 3'd1;
                    cnt_s     = CNT_ZERO;
                end else if (last_r) begin
                    state_s = LATCH;
                    cnt_s   = CNT_ZERO;
                end else if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    state_s    = GAP;
                    cnt_s      = CNT_ZERO;
                    underrun_s = 1'b1;
                end
            end
            GAP: begin
                if (accept_s) begin
                    load_s = 1'b1;
                end else if (cnt_r == RESET_END) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            LATCH: begin
                if (cnt_r == RESET_END) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        if (load_s) begin
            state_s   = BIT;
            cnt_s     = CNT_ZERO;
            sr_s      = s_data;
            last_s    = s_last;
            bit_idx_s = 3'd7;
        end else begin
            last_s = last_s;
        end
        ready_s = ready_for(state_s, cnt_s, bit_idx_s, last_s);
        ws_s    = line_for(state_s, cnt_s, sr_s[7]);
        busy_s  = (state_s != IDLE);
    end

    // State and registered outputs; outputs reflect the state entered at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            sr_r      <= 8'h00;
            bit_idx_r <= 3'd0;
            last_r    <= 1'b0;
            s_ready   <= 1'b0;
            ws_out    <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            sr_r      <= sr_s;
            bit_idx_r <= bit_idx_s;
            last_r    <= last_s;
            s_ready   <= ready_s;
            ws_out    <= ws_s;
            busy      <= busy_s;
            underrun  <= underrun_s;
        end
    end

`ifdef WS_UNDERRUN_CNT_EN
    // Saturating underrun counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= 16'h0000;
        end else if (underrun_s && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'h0001;
        end else begin
            underrun_cnt <= underrun_cnt;
        end
    end
`endif

endmodule
